// File: rtl/multicycle_controller.sv
// Main control FSM for the multicycle RV32I core. Sequences the shared
// datapath (PC, IR, register file, single ALU, unified memory) over several
// cycles per instruction. Outputs are Moore-decoded from the state register;
// only mem_ready (memory states) and zero_flg (BEQ) gate outputs directly.
//
// Memory handshake: mem_req (with MemWrite for stores) is held high in a
// memory state until the cycle where mem_ready=1; that cycle completes the
// access and the FSM advances. mem_ready is ignored in every other state.
module multicycle_controller #(
  parameter logic [3:0] RESET_STATE = 4'd0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] instr,
  input  logic        zero_flg,
  input  logic        mem_ready,
  output logic        mem_req,
  output logic        MemWrite,
  output logic        AdrSrc,
  output logic        IRWrite,
  output logic        PCWrite,
  output logic        RegWrite,
  output logic [1:0]  ResultSrc,
  output logic [1:0]  ALUSrcA,
  output logic [1:0]  ALUSrcB,
  output logic [2:0]  ALUControl,
  output logic [1:0]  ImmSrc,
  output logic        illegal_op,
  output logic        instr_done,
  output logic [3:0]  state_dbg
);

  localparam logic [3:0] S_FETCH    = 4'd0;
  localparam logic [3:0] S_DECODE   = 4'd1;
  localparam logic [3:0] S_MEMADR   = 4'd2;
  localparam logic [3:0] S_MEMREAD  = 4'd3;
  localparam logic [3:0] S_MEMWB    = 4'd4;
  localparam logic [3:0] S_MEMWRITE = 4'd5;
  localparam logic [3:0] S_EXECR    = 4'd6;
  localparam logic [3:0] S_EXECI    = 4'd7;
  localparam logic [3:0] S_ALUWB    = 4'd8;
  localparam logic [3:0] S_BEQ      = 4'd9;
  localparam logic [3:0] S_JAL      = 4'd10;

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_RTYPE = 7'b0110011;
  localparam logic [6:0] OP_ITYPE = 7'b0010011;
  localparam logic [6:0] OP_BEQ   = 7'b1100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b101;

  logic [3:0] state;
  logic [3:0] next_state;
  logic [6:0] opcode;
  logic [2:0] funct3;
  logic       funct7_b5;
  logic [2:0] funct_alu;
  logic [1:0] imm_dec;

  assign opcode    = instr[6:0];
  assign funct3    = instr[14:12];
  assign funct7_b5 = instr[30];
  assign state_dbg = state;

  // State register; reset abandons any in-flight instruction.
  always_ff @(posedge clk) begin
    if (reset) state <= RESET_STATE;
    else       state <= next_state;
  end

  // ALU operation for EXECR/EXECI; only R-type (opcode[5]=1) can select SUB.
  always_comb begin
    funct_alu = ALU_ADD;
    case (funct3)
      3'b000:  funct_alu = (opcode[5] && funct7_b5) ? ALU_SUB : ALU_ADD;
      3'b010:  funct_alu = ALU_SLT;
      3'b110:  funct_alu = ALU_OR;
      3'b111:  funct_alu = ALU_AND;
      default: funct_alu = ALU_ADD;
    endcase
  end

  // Immediate format follows the opcode regardless of state.
  always_comb begin
    imm_dec = 2'b00;
    case (opcode)
      OP_STORE: imm_dec = 2'b01;
      OP_BEQ:   imm_dec = 2'b10;
      OP_JAL:   imm_dec = 2'b11;
      default:  imm_dec = 2'b00;
    endcase
  end

  // Next-state and Moore output decode; reset overrides everything to 0.
  always_comb begin
    next_state = S_FETCH;
    mem_req    = 1'b0;
    MemWrite   = 1'b0;
    AdrSrc     = 1'b0;
    IRWrite    = 1'b0;
    PCWrite    = 1'b0;
    RegWrite   = 1'b0;
    ResultSrc  = 2'b00;
    ALUSrcA    = 2'b00;
    ALUSrcB    = 2'b00;
    ALUControl = ALU_ADD;
    ImmSrc     = imm_dec;
    illegal_op = 1'b0;
    instr_done = 1'b0;
    case (state)
      S_FETCH: begin
        mem_req    = 1'b1;
        ALUSrcB    = 2'b10;
        ResultSrc  = 2'b10;
        IRWrite    = mem_ready;
        PCWrite    = mem_ready;
        next_state = mem_ready ? S_DECODE : S_FETCH;
      end
      S_DECODE: begin
        ALUSrcA = 2'b01;
        ALUSrcB = 2'b01;
        case (opcode)
          OP_LOAD, OP_STORE: next_state = S_MEMADR;
          OP_RTYPE:          next_state = S_EXECR;
          OP_ITYPE:          next_state = S_EXECI;
          OP_BEQ:            next_state = S_BEQ;
          OP_JAL:            next_state = S_JAL;
          default: begin
            illegal_op = 1'b1;
            instr_done = 1'b1;
            next_state = S_FETCH;
          end
        endcase
      end
      S_MEMADR: begin
        ALUSrcA    = 2'b10;
        ALUSrcB    = 2'b01;
        next_state = (opcode == OP_LOAD) ? S_MEMREAD : S_MEMWRITE;
      end
      S_MEMREAD: begin
        mem_req    = 1'b1;
        AdrSrc     = 1'b1;
        next_state = mem_ready ? S_MEMWB : S_MEMREAD;
      end
      S_MEMWB: begin
        ResultSrc  = 2'b01;
        RegWrite   = 1'b1;
        instr_done = 1'b1;
      end
      S_MEMWRITE: begin
        mem_req    = 1'b1;
        MemWrite   = 1'b1;
        AdrSrc     = 1'b1;
        instr_done = mem_ready;
        next_state = mem_ready ? S_FETCH : S_MEMWRITE;
      end
      S_EXECR: begin
        ALUSrcA    = 2'b10;
        ALUControl = funct_alu;
        next_state = S_ALUWB;
      end
      S_EXECI: begin
        ALUSrcA    = 2'b10;
        ALUSrcB    = 2'b01;
        ALUControl = funct_alu;
        next_state = S_ALUWB;
      end
      S_ALUWB: begin
        RegWrite   = 1'b1;
        instr_done = 1'b1;
      end
      S_BEQ: begin
        ALUSrcA    = 2'b10;
        ALUControl = ALU_SUB;
        PCWrite    = zero_flg;
        instr_done = 1'b1;
      end
      S_JAL: begin
        ALUSrcA    = 2'b01;
        ALUSrcB    = 2'b10;
        PCWrite    = 1'b1;
        next_state = S_ALUWB;
      end
      default: next_state = S_FETCH;
    endcase
    if (reset) begin
      next_state = S_FETCH;
      mem_req    = 1'b0;
      MemWrite   = 1'b0;
      AdrSrc     = 1'b0;
      IRWrite    = 1'b0;
      PCWrite    = 1'b0;
      RegWrite   = 1'b0;
      ResultSrc  = 2'b00;
      ALUSrcA    = 2'b00;
      ALUSrcB    = 2'b00;
      ALUControl = ALU_ADD;
      ImmSrc     = 2'b00;
      illegal_op = 1'b0;
      instr_done = 1'b0;
    end
  end

endmodule
